// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: sequencing controller for an 8-to-1 bit mux.
// On start it walks sel over the enabled channels in ascending order.
// Each channel is held for SETTLE_CYCLES, then mux_out is sampled into result_data[sel].
// The finished word is offered over a valid/ready handshake.
// Optional feature macro: MUX_SCAN_PARITY_EN adds a registered result_parity output.
module mux_scan_ctrl #(
    parameter int SETTLE_CYCLES = 2    // legal range 1..255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] chan_mask,
    input  logic       abort,
    input  logic       mux_out,
    output logic [2:0] sel,
    output logic       busy,
    output logic       result_valid,
    input  logic       result_ready,
    output logic [7:0] result_data,
`ifdef MUX_SCAN_PARITY_EN
    output logic [7:0] result_mask,
    output logic       result_parity
`else
    output logic [7:0] result_mask
`endif
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [7:0]    pend_mask;
    logic [7:0]    sample_data;
    logic [7:0]    sample_mask;

    // Index of the lowest set bit; callers guarantee a non-zero mask.
    function automatic logic [2:0] lowest_bit(input logic [7:0] m);
        lowest_bit = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) lowest_bit = 3'(i);
        end
    endfunction

    // Result word and pending mask as they will look after this SAMPLE cycle.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        sample_data      = result_data;
        sample_data[sel] = mux_out;
        sample_mask      = pend_mask & ~(8'd1 << sel);
    end

    // Scan state machine; all outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            cnt           <= '0;
            pend_mask     <= 8'd0;
            sel           <= 3'd0;
            busy          <= 1'b0;
            result_valid  <= 1'b0;
            result_data   <= 8'd0;
            result_mask   <= 8'd0;
`ifdef MUX_SCAN_PARITY_EN
            result_parity <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            case (state)
                S_IDLE: begin
                    if (start && (chan_mask != 8'd0)) begin
                        pend_mask     <= chan_mask;
                        result_mask   <= chan_mask;
                        result_data   <= 8'd0;
`ifdef MUX_SCAN_PARITY_EN
                        result_parity <= 1'b0;
`endif
                        sel           <= lowest_bit(chan_mask);
                        cnt           <= '0;
                        busy          <= 1'b1;
                        state         <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (abort) begin
                        state         <= S_IDLE;
                        busy          <= 1'b0;
                        pend_mask     <= 8'd0;
                        result_data   <= 8'd0;
`ifdef MUX_SCAN_PARITY_EN
                        result_parity <= 1'b0;
`endif
                    end else if (cnt == CNT_LAST) begin
                        state <= S_SAMPLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_SAMPLE: begin
                    // Abort wins over the sample write in the same cycle.
                    if (abort) begin
                        state         <= S_IDLE;
                        busy          <= 1'b0;
                        pend_mask     <= 8'd0;
                        result_data   <= 8'd0;
`ifdef MUX_SCAN_PARITY_EN
                        result_parity <= 1'b0;
`endif
                    end else begin
                        result_data   <= sample_data;
`ifdef MUX_SCAN_PARITY_EN
                        result_parity <= ^sample_data;
`endif
                        pend_mask     <= sample_mask;
                        if (sample_mask != 8'd0) begin
                            sel   <= lowest_bit(sample_mask);
                            cnt   <= '0;
                            state <= S_SETTLE;
                        end else begin
                            result_valid <= 1'b1;
                            state        <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        busy         <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: directed bench for mux_scan_ctrl with a cycle-count based
// reference model and a per-cycle compare process.
module tb_mux_scan_ctrl;

    localparam int S = 2;
    localparam int PER = S + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       result_ready = 1'b0;
    logic [7:0] chan_mask = 8'd0;
    logic [7:0] mux_in = 8'd0;
    logic       mux_out;
    logic [2:0] sel;
    logic       busy;
    logic       result_valid;
    logic [7:0] result_data;
    logic [7:0] result_mask;
`ifdef MUX_SCAN_PARITY_EN
    logic       result_parity;
`endif

    // The mux itself: an 8-input bit selector fed by the bench.
    assign mux_out = mux_in[sel];

    always #5 clk = ~clk;

    mux_scan_ctrl #(.SETTLE_CYCLES(S)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .chan_mask    (chan_mask),
        .abort        (abort),
        .mux_out      (mux_out),
        .sel          (sel),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_data  (result_data),
`ifdef MUX_SCAN_PARITY_EN
        .result_mask  (result_mask),
        .result_parity(result_parity)
`else
        .result_mask  (result_mask)
`endif
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: elapsed cycles since an accepted start decide which
    // channel is selected and how many samples have been taken.
    logic       m_busy, m_valid;
    logic [2:0] m_sel;
    logic [7:0] m_data, m_mask;
    int         m_t, m_n, m_k;
    int         m_ch[8];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_valid = 1'b0; m_sel = 3'd0;
            m_data = 8'd0; m_mask = 8'd0; m_t = 0; m_n = 0;
        end else if (!m_busy) begin
            if (start && chan_mask != 8'd0) begin
                m_busy = 1'b1; m_t = 0; m_mask = chan_mask; m_data = 8'd0; m_n = 0;
                for (int i = 0; i < 8; i++) begin
                    if (chan_mask[i]) begin
                        m_ch[m_n] = i;
                        m_n++;
                    end
                end
                m_sel = 3'(m_ch[0]);
            end
        end else if (m_valid) begin
            if (result_ready) begin
                m_busy = 1'b0; m_valid = 1'b0;
            end
        end else if (abort) begin
            m_busy = 1'b0; m_data = 8'd0;
        end else begin
            m_t++;
            if (m_t % PER == 0) begin
                m_k = m_t / PER;
                m_data[m_ch[m_k-1]] = mux_in[m_ch[m_k-1]];
                if (m_k == m_n) m_valid = 1'b1;
                else m_sel = 3'(m_ch[m_k]);
            end
        end
    end

    // Compare process: every cycle out of reset, shortly after the edge.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            check("cyc_sel", 32'(sel), 32'(m_sel));
            check("cyc_busy", 32'(busy), 32'(m_busy));
            check("cyc_valid", 32'(result_valid), 32'(m_valid));
            check("cyc_data", 32'(result_data), 32'(m_data));
            check("cyc_mask", 32'(result_mask), 32'(m_mask));
`ifdef MUX_SCAN_PARITY_EN
            check("cyc_parity", 32'(result_parity), 32'(^m_data));
`endif
        end
    end

    task automatic do_start(input logic [7:0] m);
        @(negedge clk);
        start = 1'b1;
        chan_mask = m;
        @(negedge clk);
        start = 1'b0;
        chan_mask = 8'd0;
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!result_valid && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
        if (cycles >= 200) check("valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sel"}, 32'(sel), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_valid"}, 32'(result_valid), 32'd0);
        check({tag, "_data"}, 32'(result_data), 32'd0);
        check({tag, "_mask"}, 32'(result_mask), 32'd0);
`ifdef MUX_SCAN_PARITY_EN
        check({tag, "_parity"}, 32'(result_parity), 32'd0);
`endif
    endtask

    initial begin
        int cyc;
        int nsel;
        logic [2:0] seen[8];
        logic rose;

        // Reset state
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;

        // Full scan, inputs A5, ready held high
        mux_in = 8'hA5;
        result_ready = 1'b1;
        do_start(8'hFF);
        check("full_busy_after_start", 32'(busy), 32'd1);
        wait_valid(cyc);
        check("full_latency", 32'(cyc), 32'd24);
        check("full_data", 32'(result_data), 32'hA5);
        check("full_mask", 32'(result_mask), 32'hFF);
        check("model_pin_full", 32'(m_data), 32'hA5);
`ifdef MUX_SCAN_PARITY_EN
        check("full_parity", 32'(result_parity), 32'd0);
`endif
        @(negedge clk);
        check("full_idle_busy", 32'(busy), 32'd0);

        // Sparse mask with backpressure
        mux_in = 8'hFF;
        result_ready = 1'b0;
        do_start(8'h82);
        nsel = 1;
        seen[0] = sel;
        cyc = 0;
        while (!result_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (sel != seen[nsel-1] && nsel < 8) begin
                seen[nsel] = sel;
                nsel++;
            end
        end
        check("sparse_latency", 32'(cyc), 32'd6);
        check("sparse_nsel", 32'(nsel), 32'd2);
        check("sparse_sel0", 32'(seen[0]), 32'd1);
        check("sparse_sel1", 32'(seen[1]), 32'd7);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("sparse_hold_valid", 32'(result_valid), 32'd1);
            check("sparse_hold_data", 32'(result_data), 32'h82);
        end
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        check("sparse_busy_drop", 32'(busy), 32'd0);
        check("sparse_valid_drop", 32'(result_valid), 32'd0);
        check("sparse_data_kept", 32'(result_data), 32'h82);

        // Ignored requests: empty mask, then a start during SETTLE
        @(negedge clk);
        start = 1'b1;
        chan_mask = 8'h00;
        @(negedge clk);
        start = 1'b0;
        check("empty_busy", 32'(busy), 32'd0);
        check("empty_data", 32'(result_data), 32'h82);
        check("empty_mask", 32'(result_mask), 32'h82);
        mux_in = 8'h3C;
        result_ready = 1'b1;
        do_start(8'h0C);
        start = 1'b1;
        chan_mask = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        chan_mask = 8'h00;
        wait_valid(cyc);
        check("ignored_latency", 32'(cyc + 1), 32'd6);
        check("ignored_data", 32'(result_data), 32'h0C);
        check("ignored_mask", 32'(result_mask), 32'h0C);
        @(negedge clk);
        check("ignored_idle", 32'(busy), 32'd0);

        // Abort in the SAMPLE cycle of the third channel
        mux_in = 8'hA5;
        do_start(8'hFF);
        repeat (8) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_data", 32'(result_data), 32'd0);
        rose = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (result_valid) rose = 1'b1;
        end
        check("abort_no_valid", 32'(rose), 32'd0);
        mux_in = 8'h10;
        do_start(8'h11);
        wait_valid(cyc);
        check("post_abort_latency", 32'(cyc), 32'd6);
        check("post_abort_data", 32'(result_data), 32'h10);
        check("post_abort_mask", 32'(result_mask), 32'h11);
`ifdef MUX_SCAN_PARITY_EN
        check("post_abort_parity", 32'(result_parity), 32'd1);
`endif
        @(negedge clk);

        // Reset asserted between edges during SETTLE
        mux_in = 8'h5A;
        do_start(8'hFF);
        repeat (4) @(negedge clk);
        check("pre_rst_sel", 32'(sel), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        do_start(8'hFF);
        wait_valid(cyc);
        check("rst_scan_latency", 32'(cyc), 32'd24);
        check("rst_scan_data", 32'(result_data), 32'h5A);
        check("rst_scan_mask", 32'(result_mask), 32'hFF);
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Sequencing controller for the 8-to-1 bit mux datapath. On a start request it walks the mux select lines over a caller-supplied set of enabled channels in ascending order. For each channel it waits a programmable settle time, samples the single-bit mux output, and assembles the sampled bits into an 8-bit result word. The result is offered to a downstream consumer over a valid/ready handshake. It sits between the test/system sequencer and the mux instance, and is the only driver of the mux select lines.

## Interface

Parameters:
- SETTLE_CYCLES, 2, cycles select is held stable before sampling; legal range 1..255

Ports:
- clk  in  1  system clock, all state on posedge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle scan request, honoured only in IDLE
- chan_mask  in  8  channels to scan; bit i enables mux input i; sampled with start
- abort  in  1  cancel an in-progress scan
- mux_out  in  1  output of the 8-to-1 mux
- sel  out  3  mux select, drives the mux selection input
- busy  out  1  high from accepted start until return to IDLE
- result_valid  out  1  result word available
- result_ready  in  1  consumer accepts result
- result_data  out  8  bit i = sampled mux_out for channel i; 0 for disabled channels
- result_mask  out  8  copy of the chan_mask that produced result_data
- result_parity  out  1  XOR of result_data; present only with MUX_SCAN_PARITY_EN

## Operation

- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 and chan_mask!=0: latch the mask into pend_mask and result_mask; clear result_data; set sel to the lowest set bit of chan_mask; clear the settle counter; go to SETTLE.
  - start=1 with chan_mask==0: ignored; state and outputs are unchanged.
- SETTLE: the counter increments each cycle; when it reaches SETTLE_CYCLES-1, go to SAMPLE.
- SAMPLE (exactly one cycle):
  - Write mux_out into result_data[sel] and clear pend_mask[sel].
  - If any pend_mask bit remains set, sel moves to the next-lowest remaining bit, the counter clears, and the state returns to SETTLE.
  - Otherwise go to DONE.
- DONE: result_valid=1. result_data, result_mask and sel are held. On result_valid&&result_ready, go to IDLE.
- start is ignored in every state except IDLE, including the IDLE-return cycle's predecessor.
- abort=1 in SETTLE or SAMPLE: go to IDLE at the next edge, no result is produced, and result_data clears to 0. abort in DONE or IDLE has no effect.
- abort has priority over a SAMPLE write in the same cycle.
- sel changes only on the SETTLE entry edges listed above. It never changes during SETTLE or SAMPLE, so mux_out is stable for at least SETTLE_CYCLES cycles before sampling.
- Counter width is $clog2(SETTLE_CYCLES+1). The counter never wraps.

## Timing

- All outputs are registered.
- Reset values: sel=0, busy=0, result_valid=0, result_data=0, result_mask=0, result_parity=0, state IDLE.
- Reset asserted mid-scan forces these values immediately, independent of the clock.
- Start accepted at edge E: sel is valid after E and busy=1 after E.
- Each enabled channel occupies SETTLE_CYCLES+1 cycles. mux_out for the k-th enabled channel (k=1..N) is sampled at edge E+k*(SETTLE_CYCLES+1).
- result_valid rises after edge E+N*(SETTLE_CYCLES+1). With the default SETTLE_CYCLES=2 and all 8 channels enabled, this is 24 cycles.
- result_valid stays high and data stays stable until the handshake completes.
- The handshake completes at edge H. After H, result_valid=0, busy=0, and the state is IDLE. The earliest next start is sampled at edge H+1.
- result_data and result_mask keep their last values in IDLE until the next accepted start or an abort.

## Configuration

- MUX_SCAN_PARITY_EN defined:
  - The result_parity port exists.
  - It is registered, and updated with result_data as the XOR of all 8 result_data bits (disabled channels contribute 0).
  - It is valid whenever result_valid=1 and resets to 0.
- MUX_SCAN_PARITY_EN undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan

- Full scan:
  - Stimulus: SETTLE_CYCLES=2; chan_mask=8'hFF; the bench drives mux inputs 8'hA5; result_ready=1.
  - Required: sel steps through 0..7, each value held 3 cycles; result_valid rises 24 cycles after start; result_data=8'hA5; result_mask=8'hFF; parity=0.
- Sparse mask with backpressure:
  - Stimulus: chan_mask=8'h82; inputs 8'hFF; result_ready held 0 for 5 cycles.
  - Required: sel visits only 1 then 7; result_data=8'h82; valid and data held stable for 5 cycles; busy drops one cycle after ready.
- Ignored requests:
  - Stimulus: start with chan_mask=0, then a second start during SETTLE.
  - Required: the first start leaves busy=0 and outputs unchanged; the second start is ignored, and the original mask and timing complete unaffected.
- Abort:
  - Stimulus: abort asserted in the SAMPLE cycle of the 3rd channel of an 8'hFF scan.
  - Required: IDLE at the next edge; result_valid never rises; result_data=0; a new start is then accepted normally.
- Reset mid-scan:
  - Stimulus: rst_n pulled low between edges during SETTLE.
  - Required: all outputs go to their reset values without a clock edge; after release, start yields a correct full scan.
